// File: rtl/pe_au_seq_if.sv
// Control/handshake bundle between the AMNS PE sequencer and its neighbours:
// run request and result handshake upstream, issue and DSP control streams downstream.
interface pe_au_seq_if #(
    parameter int N = 5
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic          start_i;
    logic          cascade_i;
    logic          res_ready_i;
    logic          issue_o;
    logic [IW-1:0] idx_o;
    logic [8:0]    OPMODE_o;
    logic          CREG_en_o;
    logic          busy_o;
    logic          res_valid_o;

    // Requester / consumer side of the sequencer.
    modport master (
        output start_i, cascade_i, res_ready_i,
        input  issue_o, idx_o, OPMODE_o, CREG_en_o, busy_o, res_valid_o
    );

    // The sequencer itself.
    modport slave (
        input  start_i, cascade_i, res_ready_i,
        output issue_o, idx_o, OPMODE_o, CREG_en_o, busy_o, res_valid_o
    );
endinterface

// File: rtl/pe_au_seq.sv
// Sequencer for one DSP48E2 AMNS arithmetic unit: issues N operand pairs and
// emits OPMODE / CREG enable streams aligned to the unit's register stages.
module pe_au_seq #(
    parameter int N     = 5,
    parameter int ABREG = 1,
    parameter int MREG  = 1,
    parameter int CREG  = 1
) (
    input logic         clock_i,
    input logic         reset_i,
    pe_au_seq_if.slave  bus
);
    localparam int L  = ABREG + MREG;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (IW > 2) ? IW : 2;  // also has to count the L <= 3 drain cycles
    localparam int OD = L - 1;
    localparam int CD = L - CREG;

    localparam logic [8:0] OP_HOLD     = 9'h020;
    localparam logic [8:0] OP_MAC_C    = 9'h035;
    localparam logic [8:0] OP_MAC_P    = 9'h025;
    localparam logic [8:0] OP_MAC_PCIN = 9'h015;

    if (L < 1 || L < CREG) begin : g_bad_params
        $error("pe_au_seq: ABREG+MREG must be >= 1 and >= CREG");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESULT} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cas_q, cas_d;
    logic          issue;
    logic [8:0]    op_issue;
    logic          creg_issue;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cas_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cas_q   <= cas_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cas_d      = cas_q;
        issue      = 1'b0;
        op_issue   = OP_HOLD;
        creg_issue = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    cas_d   = bus.cascade_i;
                    cnt_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                issue = 1'b1;
                if (cnt_q == '0) begin
                    op_issue   = cas_q ? OP_MAC_PCIN : OP_MAC_C;
                    creg_issue = !cas_q;
                end else begin
                    op_issue = OP_MAC_P;
                end
                if (cnt_q == CW'(N - 1)) begin
                    cnt_d   = '0;
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                if (cnt_q == CW'(L - 1)) begin
                    cnt_d   = '0;
                    state_d = RESULT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESULT: begin
                if (bus.res_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.issue_o     = issue;
    assign bus.idx_o       = issue ? cnt_q[IW-1:0] : '0;
    assign bus.busy_o      = (state_q != IDLE);
    assign bus.res_valid_o = (state_q == RESULT);

    // OPMODE shift line: step encoding reaches the unit's OPMODE register L-1 cycles after issue.
    if (OD == 0) begin : g_op_direct
        assign bus.OPMODE_o = op_issue;
    end else begin : g_op_line
        logic [8:0] op_sr [OD];
        // NOTE: this small shift line is reset (to HOLD) because an aborted run must not leak stale ops.
        always_ff @(posedge clock_i) begin
            if (reset_i) begin
                for (int i = 0; i < OD; i++) op_sr[i] <= OP_HOLD;
            end else begin
                op_sr[0] <= op_issue;
                for (int i = 1; i < OD; i++) op_sr[i] <= op_sr[i-1];
            end
        end
        assign bus.OPMODE_o = op_sr[OD-1];
    end

    // CREG enable line: C must be captured just in time for step 0's accumulate.
    if (CD == 0) begin : g_creg_direct
        assign bus.CREG_en_o = creg_issue;
    end else begin : g_creg_line
        logic [CD-1:0] creg_sr;
        always_ff @(posedge clock_i) begin
            if (reset_i) begin
                creg_sr <= '0;
            end else if (CD == 1) begin
                creg_sr <= CD'(creg_issue);
            end else begin
                creg_sr <= {creg_sr[CD-2:0], creg_issue};
            end
        end
        assign bus.CREG_en_o = creg_sr[CD-1];
    end
endmodule

// File: tb/tb_pe_au_seq.sv
// Randomized bench for pe_au_seq: two configurations share one stimulus stream and
// are compared every cycle against a timeline model derived from the run start edge.
module tb_pe_au_seq;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    pe_au_seq_if #(.N(5)) bus0 ();
    pe_au_seq_if #(.N(1)) bus1 ();

    pe_au_seq #(.N(5), .ABREG(1), .MREG(1), .CREG(1)) dut0 (
        .clock_i(clock), .reset_i(reset), .bus(bus0)
    );
    pe_au_seq #(.N(1), .ABREG(2), .MREG(1), .CREG(1)) dut1 (
        .clock_i(clock), .reset_i(reset), .bus(bus1)
    );

    logic start = 1'b0, cascade = 1'b0, ready = 1'b0;
    assign bus0.start_i = start;  assign bus0.cascade_i = cascade;  assign bus0.res_ready_i = ready;
    assign bus1.start_i = start;  assign bus1.cascade_i = cascade;  assign bus1.res_ready_i = ready;

    logic [31:0] o_issue [2], o_idx [2], o_op [2], o_creg [2], o_busy [2], o_valid [2];
    assign o_issue[0] = 32'(bus0.issue_o);   assign o_issue[1] = 32'(bus1.issue_o);
    assign o_idx[0]   = 32'(bus0.idx_o);     assign o_idx[1]   = 32'(bus1.idx_o);
    assign o_op[0]    = 32'(bus0.OPMODE_o);  assign o_op[1]    = 32'(bus1.OPMODE_o);
    assign o_creg[0]  = 32'(bus0.CREG_en_o); assign o_creg[1]  = 32'(bus1.CREG_en_o);
    assign o_busy[0]  = 32'(bus0.busy_o);    assign o_busy[1]  = 32'(bus1.busy_o);
    assign o_valid[0] = 32'(bus0.res_valid_o); assign o_valid[1] = 32'(bus1.res_valid_o);

    // Configuration of each instance: N, latency L = ABREG+MREG, CREG.
    function automatic int cfg_n(int j);   return (j == 0) ? 5 : 1; endfunction
    function automatic int cfg_l(int j);   return (j == 0) ? 2 : 3; endfunction
    function automatic int cfg_c(int j);   return 1;                endfunction

    int  n_checks = 0;
    int  n_fail   = 0;
    int  cyc      = 0;
    bit  armed    = 1'b0;
    bit  run [2]  = '{1'b0, 1'b0};
    bit  cas [2]  = '{1'b0, 1'b0};
    int  k   [2]  = '{0, 0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Expected outputs follow directly from the run's start edge k: d = cycles since k.
    task automatic check_all();
        for (int j = 0; j < 2; j++) begin
            int nn = cfg_n(j);
            int ll = cfg_l(j);
            int cc = cfg_c(j);
            int d  = cyc - k[j];
            bit e_issue = run[j] && d >= 1 && d <= nn;
            logic [31:0] e_op = 32'h020;
            if (run[j] && d >= ll && d <= ll + nn - 1)
                e_op = (d == ll) ? (cas[j] ? 32'h015 : 32'h035) : 32'h025;
            check($sformatf("i%0d_issue", j), o_issue[j], 32'(e_issue));
            if (e_issue) check($sformatf("i%0d_idx", j), o_idx[j], 32'(d - 1));
            check($sformatf("i%0d_opmode", j), o_op[j], e_op);
            check($sformatf("i%0d_creg_en", j), o_creg[j], 32'(run[j] && !cas[j] && d == 1 + ll - cc));
            check($sformatf("i%0d_busy", j), o_busy[j], 32'(run[j]));
            check($sformatf("i%0d_res_valid", j), o_valid[j], 32'(run[j] && d >= nn + ll + 1));
        end
    endtask

    // One clock cycle: check outputs, drive inputs at the falling edge, advance the model at the rising edge.
    task automatic step(input bit s, input bit c, input bit r, input bit rs);
        @(negedge clock);
        if (armed) check_all();
        start = s; cascade = c; ready = r; reset = rs;
        @(posedge clock);
        for (int j = 0; j < 2; j++) begin
            if (rs) run[j] = 1'b0;
            else if (!run[j]) begin
                if (s) begin run[j] = 1'b1; k[j] = cyc; cas[j] = c; end
            end else if (cyc - k[j] >= cfg_n(j) + cfg_l(j) + 1 && r) begin
                run[j] = 1'b0;
            end
        end
        if (rs) armed = 1'b1;
        cyc++;
    endtask

    initial begin
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        // Nominal C-seeded run with start pulses while busy, result accepted at once.
        step(1, 0, 1, 0);
        for (int i = 1; i <= 12; i++) step(i == 2 || i == 7, 1, 1, 0);
        // PCIN-seeded run with result held for a while, then accept and immediate restart.
        step(1, 1, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 9; i++) step(0, 0, 1, 0);
        // Reset during DRAIN, then a fresh nominal run.
        step(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        step(1, 0, 1, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 1, 0);
        // Randomized traffic including rare resets.
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 79) == 0);
        step(0, 0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
